// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_pkg                                                      |
// | Shared SPARC fetch constants and address helpers.                    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package fetch_stage_pkg;

  localparam int          c_inst_w   = 32;
  localparam logic [31:0] c_nop_inst = 32'h0100_0000;
  localparam logic [31:0] c_pc_incr  = 32'd4;

  // Instruction addresses are word aligned; low bits are dropped without a trap.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/pc_npc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_npc_reg                                                           |
// | Architectural PC/nPC pair with stall, branch redirect and +4 step.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pc_npc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        le,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] npc
);

  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] w_next;

  // The delay slot is already in nPC-order when decode redirects, so the
  // redirect replaces nPC rather than PC.
  always_comb begin
    w_next = r_npc;
    if (branch_taken) begin
      w_next = word_align(branch_target);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_npc <= RESET_PC + c_pc_incr;
    end else if (le) begin
      r_pc  <= w_next;
      r_npc <= w_next + c_pc_incr;
    end
  end

  assign pc  = r_pc;
  assign npc = r_npc;

endmodule : pc_npc_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage                                                          |
// | SPARC instruction fetch: PC/nPC sequencing and the IF/ID register.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                le,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  input  logic                annul,
  input  logic [c_inst_w-1:0] inst_in,
  output logic [ADDR_W-1:0]   pc_addr,
  output logic [31:0]         pc,
  output logic [31:0]         npc,
  output logic [c_inst_w-1:0] ifid_inst,
  output logic [31:0]         ifid_pc,
  output logic                ifid_valid
);

  logic [31:0]         w_pc;
  logic [c_inst_w-1:0] r_ifid_inst;
  logic [31:0]         r_ifid_pc;
  logic                r_ifid_valid;

  pc_npc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_npc_reg (
    .clk           (clk),
    .reset         (reset),
    .le            (le),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (w_pc),
    .npc           (npc)
  );

  // Annulled words are still captured so the squashed slot is visible in debug.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_inst  <= c_nop_inst;
      r_ifid_pc    <= 32'h0000_0000;
      r_ifid_valid <= 1'b0;
    end else if (le) begin
      r_ifid_inst  <= inst_in;
      r_ifid_pc    <= w_pc;
      r_ifid_valid <= ~annul;
    end
  end

  assign pc         = w_pc;
  assign pc_addr    = w_pc[ADDR_W-1:0];
  assign ifid_inst  = r_ifid_inst;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_valid = r_ifid_valid;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stage                                                       |
// | Directed self-checking bench for fetch_stage with a synthetic ROM.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [31:0] c_nop = 32'h0100_0000;

  logic        clk;
  logic        reset;
  logic        le;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        annul;
  logic [31:0] inst_in;
  logic [7:0]  pc_addr;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_stage #(
    .ADDR_W   (8),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .le            (le),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .annul         (annul),
    .inst_in       (inst_in),
    .pc_addr       (pc_addr),
    .pc            (pc),
    .npc           (npc),
    .ifid_inst     (ifid_inst),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word at byte address a is 0xC0DE_00aa.
  function automatic logic [31:0] w(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  assign inst_in = w(pc_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] epc, input logic ev);
    check({tag, "_ifid_pc"}, ifid_pc, epc);
    check({tag, "_ifid_inst"}, ifid_inst, w(epc[7:0]));
    check({tag, "_ifid_valid"}, {31'h0, ifid_valid}, {31'h0, ev});
  endtask

  task automatic do_reset();
    reset = 1'b1; le = 1'b0; branch_taken = 1'b0; annul = 1'b0; branch_target = 32'h0;
    step();
    reset = 1'b0; le = 1'b1;
  endtask

  initial begin
    reset = 1'b1; le = 1'b0; branch_taken = 1'b0; annul = 1'b0; branch_target = 32'h0;
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_npc", npc, 32'h4);
    check("rst_addr", {24'h0, pc_addr}, 32'h0);
    check("rst_inst", ifid_inst, c_nop);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);

    // Sequential fetch
    reset = 1'b0; le = 1'b1;
    step(); check_ifid("seq0", 32'h00, 1'b1); check("seq0_addr", {24'h0, pc_addr}, 32'h04);
    step(); check_ifid("seq1", 32'h04, 1'b1); check("seq1_addr", {24'h0, pc_addr}, 32'h08);
    step(); check_ifid("seq2", 32'h08, 1'b1); check("seq2_addr", {24'h0, pc_addr}, 32'h0C);
    step(); check_ifid("seq3", 32'h0C, 1'b1); check("seq3_addr", {24'h0, pc_addr}, 32'h10);

    // Stall at PC=0x10 with a branch pulse that must be ignored
    le = 1'b0; branch_taken = 1'b1; branch_target = 32'h80; annul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h10);
      check("stall_npc", npc, 32'h14);
      check_ifid("stall", 32'h0C, 1'b1);
    end
    le = 1'b1; branch_taken = 1'b0; annul = 1'b0;
    step(); check_ifid("resume", 32'h10, 1'b1); check("resume_pc", pc, 32'h14);

    // Branch at 0x08, taken while 0x0C (delay slot) is fetched
    do_reset();
    step(); step(); step();
    check_ifid("br_at8", 32'h08, 1'b1);
    branch_taken = 1'b1; branch_target = 32'h40;
    step(); check_ifid("br_slot", 32'h0C, 1'b1);
    check("br_pc", pc, 32'h40); check("br_npc", npc, 32'h44);
    branch_taken = 1'b0;
    step(); check_ifid("br_tgt", 32'h40, 1'b1);
    step(); check_ifid("br_tgt4", 32'h44, 1'b1);

    // Same branch with the delay slot annulled
    do_reset();
    step(); step(); step();
    branch_taken = 1'b1; branch_target = 32'h40; annul = 1'b1;
    step(); check_ifid("an_slot", 32'h0C, 1'b0); check("an_pc", pc, 32'h40);
    branch_taken = 1'b0; annul = 1'b0;
    step(); check_ifid("an_tgt", 32'h40, 1'b1);

    // Misaligned target
    branch_taken = 1'b1; branch_target = 32'h43;
    step(); check("mis_pc", pc, 32'h40); check("mis_npc", npc, 32'h44);

    // Wrap of the ROM address past 0xFC
    branch_target = 32'hF8;
    step(); check("wr_addr0", {24'h0, pc_addr}, 32'hF8);
    branch_taken = 1'b0;
    step(); check("wr_addr1", {24'h0, pc_addr}, 32'hFC); check_ifid("wr1", 32'hF8, 1'b1);
    step(); check("wr_addr2", {24'h0, pc_addr}, 32'h00); check("wr_pc", pc, 32'h100);
    check_ifid("wr2", 32'hFC, 1'b1);
    step(); check("wr3_ifid_pc", ifid_pc, 32'h100); check("wr3_inst", ifid_inst, 32'hC0DE_0000);

    // Reset while stalled and mid-branch
    le = 1'b0; branch_taken = 1'b1; branch_target = 32'h80; annul = 1'b1; reset = 1'b1;
    step();
    check("mr_pc", pc, 32'h0);
    check("mr_npc", npc, 32'h4);
    check("mr_inst", ifid_inst, c_nop);
    check("mr_ifid_pc", ifid_pc, 32'h0);
    check("mr_valid", {31'h0, ifid_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
